// File: rtl/xcore_flush_ctrl_pkg.sv
// Shared types for the flush/redirect controller: FSM state encoding and
// event-source codes, plus the fixed-priority event picker.
package xcore_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef logic [1:0] src_t;

    localparam src_t SRC_NONE   = 2'd0;
    localparam src_t SRC_TRAP   = 2'd1;
    localparam src_t SRC_BJP    = 2'd2;
    localparam src_t SRC_FENCEI = 2'd3;

    // Traps are taken in any state; branch and fence.i only while idle.
    function automatic src_t pick_src(input logic trap, input logic bjp,
                                      input logic fencei, input logic idle);
        src_t src;
        if (trap) begin
            src = SRC_TRAP;
        end else if (idle && bjp) begin
            src = SRC_BJP;
        end else if (idle && fencei) begin
            src = SRC_FENCEI;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/xcore_perf_cnt.sv
// Wrapping event counter used for the branch-mispredict statistic.
module xcore_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: add one per event, wrapping naturally at 2^W.
    always_comb begin
        if (i_inc) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/xcore_flush_ctrl.sv
// Pipeline flush / fetch-redirect controller (trap > bjp > fence.i).
// Mispredict counter is built only when XCORE_FLUSH_CNT_EN is defined.
module xcore_flush_ctrl
    import xcore_flush_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ID_W  = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bjp_flush_req,
    input  logic             i_bjp_flush_type,
    input  logic [XLEN-1:0]  i_bjp_target,
    input  logic [ID_W-1:0]  i_bjp_flush_id,
    input  logic             i_trap_req,
    input  logic [XLEN-1:0]  i_trap_target,
    input  logic [ID_W-1:0]  i_trap_id,
    input  logic             i_fencei_req,
    input  logic [XLEN-1:0]  i_fencei_target,
    input  logic [ID_W-1:0]  i_fencei_id,
    input  logic             i_lsu_idle,
    input  logic             i_ifu_ready,
    output logic             o_redir_valid,
    output logic [XLEN-1:0]  o_redir_pc,
    output logic             o_flush,
    output logic [ID_W-1:0]  o_flush_id,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            flush_q, flush_d;
    logic            valid_q, valid_d;
    logic            stall_q, stall_d;
    src_t            src_s;

    // Event acceptance, target/id capture and next-state selection.
    always_comb begin
        src_s   = pick_src(i_trap_req, i_bjp_flush_req, i_fencei_req,
                           (state_q == ST_IDLE));
        state_d = state_q;
        pc_d    = pc_q;
        id_d    = id_q;
        flush_d = 1'b0;
        case (src_s)
            SRC_TRAP: begin
                pc_d    = i_trap_target;
                id_d    = i_trap_id;
                flush_d = 1'b1;
                state_d = ST_REDIRECT;
            end
            SRC_BJP: begin
                pc_d    = i_bjp_target;
                id_d    = i_bjp_flush_id;
                flush_d = 1'b1;
                if (i_bjp_flush_type) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            SRC_FENCEI: begin
                pc_d    = i_fencei_target;
                id_d    = i_fencei_id;
                flush_d = 1'b1;
                state_d = ST_DRAIN;
            end
            default: begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_DRAIN: begin
                        if (i_lsu_idle) begin
                            state_d = ST_REDIRECT;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                    ST_REDIRECT: begin
                        if (i_ifu_ready) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REDIRECT;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        endcase
        // Outputs are registered copies of what the next state implies.
        valid_d = (state_d == ST_REDIRECT);
        stall_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= {XLEN{1'b0}};
            id_q    <= {ID_W{1'b0}};
            flush_q <= 1'b0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
            flush_q <= flush_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign o_redir_valid = valid_q;
    assign o_redir_pc    = pc_q;
    assign o_flush       = flush_q;
    assign o_flush_id    = id_q;
    assign o_stall       = stall_q;

`ifdef XCORE_FLUSH_CNT_EN
    logic bjp_acc_s;
    assign bjp_acc_s = (src_s == SRC_BJP);

    xcore_perf_cnt #(
        .W (CNT_W)
    ) u_perf_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (bjp_acc_s),
        .o_cnt   (o_mispred_cnt)
    );
`else
    assign o_mispred_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_xcore_flush_ctrl.sv
// Directed, table-driven bench for xcore_flush_ctrl (CNT_W=3 so wrap is reachable).
module tb_xcore_flush_ctrl;

    localparam int XLEN  = 32;
    localparam int ID_W  = 3;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bjp_req = 1'b0, bjp_type = 1'b0, trap_req = 1'b0, fen_req = 1'b0;
    logic [XLEN-1:0]  bjp_tgt = 32'h0, trap_tgt = 32'h0, fen_tgt = 32'h0;
    logic [ID_W-1:0]  bjp_id = 3'd0, trap_id = 3'd0, fen_id = 3'd0;
    logic             lsu_idle = 1'b0, ifu_ready = 1'b0;
    logic             redir_valid, flush, stall;
    logic [XLEN-1:0]  redir_pc;
    logic [ID_W-1:0]  flush_id;
    logic [CNT_W-1:0] mispred_cnt;

    int               n_chk = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] cnt_exp = 3'd0;

    always #5 clk = ~clk;

    xcore_flush_ctrl #(.XLEN(XLEN), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_bjp_flush_req(bjp_req), .i_bjp_flush_type(bjp_type),
        .i_bjp_target(bjp_tgt), .i_bjp_flush_id(bjp_id),
        .i_trap_req(trap_req), .i_trap_target(trap_tgt), .i_trap_id(trap_id),
        .i_fencei_req(fen_req), .i_fencei_target(fen_tgt), .i_fencei_id(fen_id),
        .i_lsu_idle(lsu_idle), .i_ifu_ready(ifu_ready),
        .o_redir_valid(redir_valid), .o_redir_pc(redir_pc),
        .o_flush(flush), .o_flush_id(flush_id),
        .o_stall(stall), .o_mispred_cnt(mispred_cnt)
    );

    typedef struct {
        logic        trap;  logic [31:0] tt; logic [2:0] tid;
        logic        bjp;   logic btype; logic [31:0] bt; logic [2:0] bid;
        logic        fen;   logic [31:0] ft; logic [2:0] fid;
        logic        lsu;   logic rdy;
        logic        ev;    logic [31:0] epc;
        logic        ef;    logic [2:0] eid;
        logic        es;    logic cinc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic trap, input logic [31:0] tt, input logic [2:0] tid,
                               input logic bjp, input logic btype, input logic [31:0] bt,
                               input logic [2:0] bid, input logic fen, input logic [31:0] ft,
                               input logic [2:0] fid, input logic lsu, input logic rdy,
                               input logic ev, input logic [31:0] epc, input logic ef,
                               input logic [2:0] eid, input logic es, input logic cinc);
        vec_t r;
        r.trap = trap; r.tt = tt; r.tid = tid;
        r.bjp = bjp; r.btype = btype; r.bt = bt; r.bid = bid;
        r.fen = fen; r.ft = ft; r.fid = fid; r.lsu = lsu; r.rdy = rdy;
        r.ev = ev; r.epc = epc; r.ef = ef; r.eid = eid; r.es = es; r.cinc = cinc;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        trap_req = 1'b0; bjp_req = 1'b0; bjp_type = 1'b0; fen_req = 1'b0;
        lsu_idle = 1'b0; ifu_ready = 1'b0;
    endtask

    task automatic bump_cnt(input logic inc);
`ifdef XCORE_FLUSH_CNT_EN
        if (inc) cnt_exp = cnt_exp + 3'd1;
`else
        if (inc) cnt_exp = 3'd0;
`endif
    endtask

    task automatic check_idle_outputs(input string nm, input int row);
        chk({nm, "_valid"}, row, {31'd0, redir_valid}, 32'd0);
        chk({nm, "_flush"}, row, {31'd0, flush}, 32'd0);
        chk({nm, "_stall"}, row, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        // trap(tt,tid) bjp(type,bt,bid) fen(ft,fid) lsu rdy | ev epc ef eid es cinc
        // bjp redirect to 0x1000 id5, fetch not ready for 3 cycles
        tbl.push_back(v(0,0,0, 1,1,32'h1000,5, 0,0,0, 0,0, 1,32'h1000,1,5,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,0, 1,32'h1000,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,0, 1,32'h1000,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,0, 1,32'h1000,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,1, 0,0,0,0,0,0));
        // trap, bjp and fencei together the very next cycle: trap only
        tbl.push_back(v(1,32'h80,2, 1,1,32'h3000,4, 1,32'h4004,6, 0,0, 1,32'h80,1,2,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,1, 0,0,0,0,0,0));
        // fencei, store path busy 4 cycles; ifu_ready ignored in DRAIN
        tbl.push_back(v(0,0,0, 0,0,0,0, 1,32'h104,1, 0,0, 0,0,1,1,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       0,1, 0,0,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       0,1, 0,0,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       0,0, 0,0,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       1,1, 1,32'h104,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       0,1, 0,0,0,0,0,0));
        // fencei with store path already idle: DRAIN still one cycle
        tbl.push_back(v(0,0,0, 0,0,0,0, 1,32'h208,0, 1,0, 0,0,1,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       1,0, 1,32'h208,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,       0,1, 0,0,0,0,0,0));
        // bjp to 0x2000; bjp/fencei ignored while busy; trap preempts
        tbl.push_back(v(0,0,0, 1,1,32'h2000,3, 0,0,0, 0,0, 1,32'h2000,1,3,1,1));
        tbl.push_back(v(0,0,0, 1,1,32'h3300,1, 0,0,0, 0,0, 1,32'h2000,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 1,32'h500,4,   1,0, 1,32'h2000,0,0,1,0));
        tbl.push_back(v(1,32'h200,7, 0,0,0,0, 0,0,0,   0,0, 1,32'h200,1,7,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,         0,0, 1,32'h200,0,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,         0,1, 0,0,0,0,0,0));
        // trap arriving with ifu_ready wins
        tbl.push_back(v(0,0,0, 1,1,32'h2000,3, 0,0,0, 0,0, 1,32'h2000,1,3,1,1));
        tbl.push_back(v(1,32'h240,6, 0,0,0,0, 0,0,0,   0,1, 1,32'h240,1,6,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,         0,1, 0,0,0,0,0,0));
        // trap preempting DRAIN
        tbl.push_back(v(0,0,0, 0,0,0,0, 1,32'h300,2,   0,0, 0,0,1,2,1,0));
        tbl.push_back(v(1,32'h380,5, 0,0,0,0, 0,0,0,   0,0, 1,32'h380,1,5,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,0, 0,0,0,         0,1, 0,0,0,0,0,0));
        // flush-only branches, including back to back
        tbl.push_back(v(0,0,0, 1,0,32'h5000,6, 0,0,0, 0,0, 0,0,1,6,0,1));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,0, 0,0,0,0,0,0));
        tbl.push_back(v(0,0,0, 1,0,32'h5004,1, 0,0,0, 0,0, 0,0,1,1,0,1));
        tbl.push_back(v(0,0,0, 1,0,32'h5008,2, 0,0,0, 0,0, 0,0,1,2,0,1));
        tbl.push_back(v(0,0,0, 0,0,0,0,       0,0,0, 0,0, 0,0,0,0,0,0));

        // reset state
        idle_inputs();
        #3;
        check_idle_outputs("reset", -1);
        chk("reset_pc", -1, redir_pc, 32'd0);
        chk("reset_id", -1, {29'd0, flush_id}, 32'd0);
        chk("reset_cnt", -1, {29'd0, mispred_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            trap_req = tbl[i].trap; trap_tgt = tbl[i].tt; trap_id = tbl[i].tid;
            bjp_req = tbl[i].bjp; bjp_type = tbl[i].btype; bjp_tgt = tbl[i].bt; bjp_id = tbl[i].bid;
            fen_req = tbl[i].fen; fen_tgt = tbl[i].ft; fen_id = tbl[i].fid;
            lsu_idle = tbl[i].lsu; ifu_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            bump_cnt(tbl[i].cinc);
            chk("valid", i, {31'd0, redir_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) chk("pc", i, redir_pc, tbl[i].epc);
            chk("flush", i, {31'd0, flush}, {31'd0, tbl[i].ef});
            if (tbl[i].ef) chk("flush_id", i, {29'd0, flush_id}, {29'd0, tbl[i].eid});
            chk("stall", i, {31'd0, stall}, {31'd0, tbl[i].es});
            chk("cnt", i, {29'd0, mispred_cnt}, {29'd0, cnt_exp});
        end

        // four more flush-only branches: ten accepted in total, count wraps 7 -> 0 -> 2
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            bjp_req = 1'b1; bjp_type = 1'b0; bjp_tgt = 32'h6000; bjp_id = 3'd3;
            @(posedge clk);
            #1;
            bump_cnt(1'b1);
            chk("wrap_flush", 100 + k, {31'd0, flush}, 32'd1);
            chk("wrap_valid", 100 + k, {31'd0, redir_valid}, 32'd0);
            chk("wrap_cnt", 100 + k, {29'd0, mispred_cnt}, {29'd0, cnt_exp});
        end
`ifdef XCORE_FLUSH_CNT_EN
        chk("wrap_final", 104, {29'd0, mispred_cnt}, 32'd2);
`else
        chk("wrap_final", 104, {29'd0, mispred_cnt}, 32'd0);
`endif

        // reset asserted mid-REDIRECT
        @(negedge clk);
        idle_inputs();
        bjp_req = 1'b1; bjp_type = 1'b1; bjp_tgt = 32'h7000; bjp_id = 3'd4;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 200, {31'd0, redir_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst", 201);
        chk("async_rst_pc", 201, redir_pc, 32'd0);
        chk("async_rst_id", 201, {29'd0, flush_id}, 32'd0);
        chk("async_rst_cnt", 201, {29'd0, mispred_cnt}, 32'd0);
        cnt_exp = 3'd0;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_idle_outputs("post_rst", 210 + k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xcore_flush_ctrl.md
XCORE_FLUSH_CTRL -- requirements
Module: xcore_flush_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the PC/target width.
REQ-002 SHALL have parameter ID_W, default 3, giving the instruction-id width.
REQ-003 SHALL have parameter CNT_W, default 32, giving the mispredict counter width.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port i_bjp_flush_req, input, 1, branch-unit mispredict flush request.
REQ-007 SHALL have port i_bjp_flush_type, input, 1, branch flush type: 1 means flush plus redirect to target, 0 means flush only.
REQ-008 SHALL have ports i_bjp_target (input, XLEN) and i_bjp_flush_id (input, ID_W), the branch-unit redirect PC and instruction id.
REQ-009 SHALL have ports i_trap_req (input, 1), i_trap_target (input, XLEN) and i_trap_id (input, ID_W), the trap/exception redirect source.
REQ-010 SHALL have ports i_fencei_req (input, 1), i_fencei_target (input, XLEN) and i_fencei_id (input, ID_W), the fence.i redirect source, where the target is pc+4.
REQ-011 SHALL have port i_lsu_idle, input, 1, high when the store path is drained.
REQ-012 SHALL have port i_ifu_ready, input, 1, fetch unit accepts the redirect.
REQ-013 SHALL have ports o_redir_valid (output, 1) and o_redir_pc (output, XLEN), the redirect handshake to the fetch unit.
REQ-014 SHALL have ports o_flush (output, 1) and o_flush_id (output, ID_W), the one-cycle younger-instruction kill and its id.
REQ-015 SHALL have port o_stall, output, 1, front-end and issue hold.
REQ-016 SHALL have port o_mispred_cnt, output, CNT_W, the accepted branch-flush count.

Function
REQ-017 SHALL implement a FSM with states IDLE, DRAIN and REDIRECT, plus an internal FLUSH_ONLY pulse path.
REQ-018 SHALL, in IDLE, accept at most one event per cycle with priority trap > bjp > fencei; lower-priority simultaneous requests are dropped.
REQ-019 SHALL, when accepting an event, register its target and id on that edge.
REQ-020 SHALL route an accepted trap, or an accepted bjp with type=1, to REDIRECT.
REQ-021 SHALL route an accepted fencei to DRAIN.
REQ-022 SHALL handle an accepted bjp with type=0 as flush only: o_flush high for exactly one cycle, o_redir_valid never asserted, FSM stays IDLE.
REQ-023 SHALL, in DRAIN, hold o_stall=1 and move to REDIRECT on the first cycle i_lsu_idle=1; if i_lsu_idle is high in the acceptance cycle, DRAIN still lasts 1 cycle.
REQ-024 SHALL, in REDIRECT, hold o_redir_valid=1 with o_redir_pc stable until the cycle where i_ifu_ready=1, then return to IDLE on that edge.
REQ-025 SHALL assert o_flush for exactly the first cycle of REDIRECT, or of DRAIN for fencei, so that o_flush occurs 1 cycle after acceptance.
REQ-026 SHALL drive o_flush_id from the captured id whenever o_flush=1.
REQ-027 SHALL drive o_stall=1 in DRAIN and REDIRECT, and o_stall=0 in IDLE.
REQ-028 SHALL ignore i_bjp_flush_req and i_fencei_req outside IDLE.
REQ-029 SHALL preempt on i_trap_req in DRAIN or REDIRECT: recapture trap target/id, re-enter REDIRECT, and re-pulse o_flush the next cycle.
REQ-030 SHALL let a trap that arrives in the same cycle as i_ifu_ready win; the handshake completes and the trap is accepted.
REQ-031 SHALL, when o_redir_valid and i_ifu_ready are both high, complete the handshake with no extra bubble; IDLE accepts a new event the following cycle.

Reset
REQ-032 SHALL, on i_rst_n low, immediately force: state IDLE; o_redir_valid, o_flush, o_stall = 0; o_redir_pc, o_flush_id = 0; o_mispred_cnt = 0.
REQ-033 SHALL abandon any in-flight redirect when reset asserts mid-operation, with no pulse emitted after release.

Configuration
REQ-034 SHALL, with macro XCORE_FLUSH_CNT_EN defined, increment o_mispred_cnt by 1 on each accepted bjp event of either type, wrapping modulo 2^CNT_W.
REQ-035 SHALL, without XCORE_FLUSH_CNT_EN, tie o_mispred_cnt to 0 and instantiate no counter flops.

Structure
REQ-036 SHALL place the FSM state encoding typedef and the event-source encoding constants in the shared params package.
REQ-037 SHALL, when XCORE_FLUSH_CNT_EN is defined, implement the counter as sub-module xcore_perf_cnt.

Verification
REQ-038 SHALL cover: bjp type=1, target 0x0000_1000, id 5, i_ifu_ready held 0 for 3 cycles -> o_flush at cycle+1 with id 5; o_redir_valid/o_redir_pc=0x1000 stable 4 cycles; o_stall falls after the handshake.
REQ-039 SHALL cover: trap (0x0000_0080), bjp and fencei all in the same cycle -> only the trap is redirected; o_mispred_cnt unchanged.
REQ-040 SHALL cover: fencei with i_lsu_idle low for 4 cycles -> stall throughout DRAIN; o_redir_pc=pc+4 only after i_lsu_idle rises.
REQ-041 SHALL cover: trap during REDIRECT of a bjp to 0x2000 -> o_redir_pc switches to the trap target; a second o_flush pulse occurs.
REQ-042 SHALL cover: bjp type=0 -> a single o_flush pulse, no redirect; counter wraps from 2^CNT_W-1 to 0 with the macro defined, and stays 0 without it.
REQ-043 SHALL cover: reset asserted mid-REDIRECT -> all outputs 0 asynchronously; after release, no flush pulse is emitted.
